// File: rtl/box_pkg.sv
// Shared state type and default widths for the box_cmd_seq register-box sequencer.
package box_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

endpackage

// File: rtl/box_timeout_ctr.sv
// Read-wait timeout counter: cleared outside the read phase, counts up while enabled
// and flags expiry on its LIMIT-th counted cycle.
module box_timeout_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Saturates at the expiry value so a stalled read never wraps back to "fresh".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/box_cmd_seq.sv
// Command sequencer turning upstream read/write commands into register-box accesses.
// Define BOX_CMD_SEQ_RDBACK_EN to follow every write with a verifying read-back.
module box_cmd_seq
  import box_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              read_enable,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_active,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy
);

  state_t state;
  logic   to_clear;
  logic   to_enable;
  logic   to_expired;
`ifdef BOX_CMD_SEQ_RDBACK_EN
  logic   rdback;
`endif

  assign to_clear  = (state != RD);
  assign to_enable = (state == RD);

  box_timeout_ctr #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expired(to_expired)
  );

  // address/write_data double as the latched command fields, so they naturally
  // hold their last values once the access is over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      write_data   <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
`ifdef BOX_CMD_SEQ_RDBACK_EN
      rdback       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            address   <= cmd_addr;
`ifdef BOX_CMD_SEQ_RDBACK_EN
            rdback    <= cmd_write;
`endif
            if (cmd_write) begin
              write_data   <= cmd_wdata;
              write_enable <= 1'b1;
              state        <= WR;
            end else begin
              read_enable <= 1'b1;
              state       <= RD;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          write_enable <= 1'b0;
`ifdef BOX_CMD_SEQ_RDBACK_EN
          read_enable  <= 1'b1;
          state        <= RD;
`else
          rsp_valid    <= 1'b1;
          rsp_data     <= write_data;
          rsp_err      <= 1'b0;
          state        <= RESP;
`endif
        end
        RD: begin
          // A late read_active on the expiry cycle still counts as a good read.
          if (read_active) begin
            read_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= read_data;
`ifdef BOX_CMD_SEQ_RDBACK_EN
            rsp_err     <= rdback && (read_data != write_data);
`else
            rsp_err     <= 1'b0;
`endif
            state       <= RESP;
          end else if (to_expired) begin
            read_enable <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_err     <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_box_cmd_seq.sv
// Bench for box_cmd_seq: directed corner cases plus randomized transactions scored
// against a transaction-level model of the register box (honours BOX_CMD_SEQ_RDBACK_EN).
module tb_box_cmd_seq;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TO = 8;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          read_enable;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          read_active;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] box_mem   [NREG];
  logic [DW-1:0] model_mem [NREG];
  logic [DW-1:0] last_wd;

  box_cmd_seq #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .read_enable (read_enable),
    .write_enable(write_enable),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .read_active (read_active),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full command/response transaction, starting and ending on a falling edge.
  // mask corrupts the register box's read-back of a just-written value.
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int ra_delay, input int stall, input logic hold,
                                input logic [DW-1:0] mask);
    int            n;
    int            lat;
    int            we_n;
    int            re_n;
    int            exp_re;
    int            exp_lat;
    logic          needs_read;
    logic [DW-1:0] exp_data;
    logic          exp_err;

    needs_read = !w;
    exp_err    = 1'b0;
    exp_re     = 0;
    exp_data   = w ? d : model_mem[a];
`ifdef BOX_CMD_SEQ_RDBACK_EN
    if (w) begin
      needs_read = 1'b1;
      exp_data   = d ^ mask;
      exp_err    = (mask != '0);
    end
`endif
    if (needs_read) begin
      if (ra_delay + 1 <= TO) begin
        exp_re = ra_delay + 1;
      end else begin
        exp_re   = TO;
        exp_data = '0;
        exp_err  = 1'b1;
      end
    end
    exp_lat = int'(w) + exp_re + 1;
    if (w) begin
      model_mem[a] = d;
      last_wd      = d;
    end

    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("cmd_ready_wait", 32'(cmd_ready), 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);

    lat  = 1;
    we_n = 0;
    re_n = 0;
    while (!rsp_valid && lat < 40) begin
      check_output("we_re_exclusive", 32'(read_enable & write_enable), 0);
      if (write_enable) begin
        we_n++;
        check_output("wr_address", 32'(address), 32'(a));
        check_output("wr_data", 32'(write_data), 32'(d));
        box_mem[address] = write_data;
      end
      if (read_enable) begin
        re_n++;
        check_output("rd_address", 32'(address), 32'(a));
        read_active = (re_n >= ra_delay + 1);
        read_data   = read_active ? (box_mem[address] ^ (w ? mask : '0)) : DW'($urandom);
      end else begin
        read_active = 1'b0;
        read_data   = DW'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    read_active = 1'b0;

    check_output("rsp_valid", 32'(rsp_valid), 1);
    if (!rsp_valid) return;
    check_output("rsp_latency", lat, exp_lat);
    check_output("we_cycles", we_n, int'(w));
    check_output("re_cycles", re_n, exp_re);
    check_output("rsp_data", 32'(rsp_data), 32'(exp_data));
    check_output("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_output("resp_busy", 32'(busy), 1);
    check_output("resp_cmd_ready", 32'(cmd_ready), 0);
    check_output("hold_address", 32'(address), 32'(a));
    check_output("hold_write_data", 32'(write_data), 32'(last_wd));

    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      if (hold) begin
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
      end
      @(negedge clk);
      check_output("stall_rsp_valid", 32'(rsp_valid), 1);
      check_output("stall_rsp_data", 32'(rsp_data), 32'(exp_data));
      check_output("stall_rsp_err", 32'(rsp_err), 32'(exp_err));
      check_output("stall_cmd_ready", 32'(cmd_ready), 0);
      check_output("stall_no_accept", 32'({read_enable, write_enable}), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check_output("post_rsp_valid", 32'(rsp_valid), 0);
    check_output("post_cmd_ready", 32'(cmd_ready), 0);
    check_output("post_busy", 32'(busy), 0);
    check_output("post_no_accept", 32'({read_enable, write_enable}), 0);
    @(negedge clk);
    check_output("idle_cmd_ready", 32'(cmd_ready), 1);
  endtask

  initial begin
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] mask;

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    read_active = 1'b0;
    read_data   = '0;
    last_wd     = '0;
    for (int i = 0; i < NREG; i++) begin
      model_mem[i] = DW'($urandom);
      box_mem[i]   = model_mem[i];
    end
    model_mem[1] = 8'h55;
    box_mem[1]   = 8'h55;

    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b0;
    #2;
    check_output("reset_ctrl_outputs",
                 32'({cmd_ready, read_enable, write_enable, rsp_valid, rsp_err, busy}), 0);
    check_output("reset_data_outputs", 32'({address, write_data, rsp_data}), 0);
    repeat (2) @(negedge clk);
    check_output("reset_held_cmd_ready", 32'(cmd_ready), 0);
    rst = 1'b1;
    check_output("release_cmd_ready_pre_edge", 32'(cmd_ready), 0);
    @(negedge clk);
    check_output("release_cmd_ready", 32'(cmd_ready), 1);

    $display("[TB] directed write / read / timeout / backpressure");
    apply_stimulus(1'b1, 2'd0, 8'hAA, 1, 0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'd1, 8'h00, 1, 0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'd2, 8'h00, 1000, 0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'd1, 8'h00, TO - 1, 0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'd0, 8'h00, TO - 2, 0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 2'd3, 8'h00, 2, 5, 1'b1, 8'h00);

`ifdef BOX_CMD_SEQ_RDBACK_EN
    $display("[TB] directed read-back mismatch / match");
    apply_stimulus(1'b1, 2'd2, 8'h3C, 1, 0, 1'b0, 8'h01);
    apply_stimulus(1'b1, 2'd2, 8'h3C, 1, 0, 1'b0, 8'h00);
`endif

    $display("[TB] reset in the middle of a read");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("mid_rd_read_enable", 32'(read_enable), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_read_enable", 32'(read_enable), 0);
    check_output("async_rst_rsp_valid", 32'(rsp_valid), 0);
    check_output("async_rst_cmd_ready", 32'(cmd_ready), 0);
    check_output("async_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    last_wd = '0;
    @(negedge clk);
    check_output("rerelease_cmd_ready", 32'(cmd_ready), 1);
    apply_stimulus(1'b0, 2'd1, 8'h00, 2, 1, 1'b0, 8'h00);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 30; t++) begin
      w = 1'($urandom);
      a = AW'($urandom);
      d = DW'($urandom);
`ifdef BOX_CMD_SEQ_RDBACK_EN
      mask = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(1, 255)) : '0;
`else
      mask = '0;
`endif
      apply_stimulus(w, a, d, int'($urandom_range(1, TO + 2)), int'($urandom_range(0, 3)),
                     1'($urandom), mask);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
